// File: rtl/cell_queue_buffer_pkg.sv
// Shared types for the cell queue buffer: controller state and per-queue linked-list state.
// Pointer/count widths are sized for 64 cell slots and 63 cells per queue.
package genericSwitchPkg;
    localparam int qPtrWidth   = 6;
    localparam int qCountWidth = 6;

    typedef enum logic {
        INIT,
        RUN
    } bufState_e;

    typedef struct packed {
        logic [qPtrWidth-1:0]   head;
        logic [qPtrWidth-1:0]   tail;
        logic [qCountWidth-1:0] count;
    } queueState_t;
endpackage

// File: rtl/cell_queue_buffer_fifo.sv
// Free-address list: circular FIFO with combinational head, pointers wrap modulo depth.
module freeAddrFifo #(
    parameter int depth = 64,
    parameter int width = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [width-1:0]       pushData,
    input  logic                   pop,
    output logic [width-1:0]       popData,
    output logic [$clog2(depth):0] count
);
    localparam int ptrWidth   = $clog2(depth);
    localparam int countWidth = ptrWidth + 1;

    logic [width-1:0]    mem [depth];
    logic [ptrWidth-1:0] wrPtr;
    logic [ptrWidth-1:0] rdPtr;

    assign popData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + countWidth'(push) - countWidth'(pop);
        end
    end
endmodule

// File: rtl/cell_queue_buffer_mem.sv
// Cell storage: one write port, one read port with a registered (1-cycle) read.
module twoPortMem #(
    parameter int dataWidth = 512,
    parameter int depth     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [$clog2(depth)-1:0] wrAddr,
    input  logic [dataWidth-1:0]     wrData,
    input  logic                     rdEn,
    input  logic [$clog2(depth)-1:0] rdAddr,
    output logic [dataWidth-1:0]     rdData
);
    logic [dataWidth-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Read data holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) rdData <= '0;
        else if (rdEn) rdData <= mem[rdAddr];
    end
endmodule

// File: rtl/cell_queue_buffer.sv
// Shared cell buffer holding nbrOfQueues linked-list output queues over one pool of cell slots.
//   state | meaning
//   INIT  | loading every cell address into the free list, one per cycle
//   RUN   | accepting enqueues/dequeues
module cell_queue_buffer
    import genericSwitchPkg::*;
#(
    parameter int nbrOfQueues      = 4,
    parameter int cellWidth        = 512,
    parameter int addresses        = 64,
    parameter int maxCellsPerQueue = 32
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  enqValid,
    input  logic [$clog2(nbrOfQueues)-1:0]                        enqQueue,
    input  logic [cellWidth-1:0]                                  enqData,
    output logic                                                  enqAccept,
    output logic                                                  enqReject,
    output logic [$clog2(addresses)-1:0]                          enqAddress,
    input  logic                                                  deqReq,
    input  logic [$clog2(nbrOfQueues)-1:0]                        deqQueue,
    output logic                                                  deqError,
    output logic                                                  deqDataValid,
    output logic [cellWidth-1:0]                                  deqData,
    output logic [nbrOfQueues-1:0]                                queueEmpty,
    output logic [nbrOfQueues-1:0][$clog2(maxCellsPerQueue+1)-1:0] queueCount,
    output logic [$clog2(addresses):0]                            freeCount,
    output logic                                                  initDone
);
    localparam int addressWidth = $clog2(addresses);
    localparam int countWidth   = $clog2(maxCellsPerQueue + 1);
    localparam logic [addressWidth-1:0] lastAddr = addressWidth'(addresses - 1);
    localparam logic [qCountWidth-1:0]  maxCount = qCountWidth'(maxCellsPerQueue);

    bufState_e               state, stateNext;
    logic [addressWidth-1:0] initLeft;
    queueState_t             qState [nbrOfQueues];
    logic [addressWidth-1:0] nextPtr [addresses];

    logic                    deqOk, freePush, linkTail;
    logic [addressWidth-1:0] freePushData, freeHead, deqHead, enqTail;
    logic [qCountWidth-1:0]  enqCnt, deqCnt;
    logic [nbrOfQueues-1:0]  enqHit, deqHit;

    assign initDone = (state == RUN);
    assign enqCnt   = qState[enqQueue].count;
    assign deqCnt   = qState[deqQueue].count;
    assign deqHead  = addressWidth'(qState[deqQueue].head);
    assign enqTail  = addressWidth'(qState[enqQueue].tail);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            initLeft <= lastAddr;
        end else begin
            state <= stateNext;
            if (state == INIT) initLeft <= initLeft - 1'b1;
        end
    end

    always_comb begin
        stateNext    = state;
        enqAccept    = 1'b0;
        enqReject    = 1'b0;
        enqAddress   = '0;
        deqError     = 1'b0;
        deqOk        = 1'b0;
        freePush     = 1'b0;
        freePushData = '0;
        linkTail     = 1'b0;
        enqHit       = '0;
        deqHit       = '0;
        case (state)
            INIT: begin
                freePush     = 1'b1;
                freePushData = lastAddr - initLeft;
                enqReject    = enqValid;
                if (initLeft == '0) stateNext = RUN;
            end
            RUN: begin
                // Limit and free-space checks use pre-dequeue values on purpose.
                enqAccept    = enqValid && (freeCount != '0) && (enqCnt < maxCount);
                enqReject    = enqValid && !enqAccept;
                deqOk        = deqReq && (deqCnt != '0);
                deqError     = deqReq && (deqCnt == '0);
                enqAddress   = enqAccept ? freeHead : '0;
                freePush     = deqOk;
                freePushData = deqHead;
                linkTail     = enqAccept && (enqCnt != '0);
            end
            default: stateNext = INIT;
        endcase
        if (rst) begin
            enqAccept  = 1'b0;
            enqReject  = 1'b0;
            enqAddress = '0;
            deqError   = 1'b0;
            deqOk      = 1'b0;
            freePush   = 1'b0;
            linkTail   = 1'b0;
        end
        if (enqAccept) enqHit[enqQueue] = 1'b1;
        if (deqOk) deqHit[deqQueue] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < nbrOfQueues; i++) qState[i] <= '0;
            deqDataValid <= 1'b0;
        end else begin
            deqDataValid <= deqOk;
            for (int i = 0; i < nbrOfQueues; i++) begin
                case ({enqHit[i], deqHit[i]})
                    2'b10: begin
                        if (qState[i].count == '0) qState[i].head <= qPtrWidth'(freeHead);
                        qState[i].tail  <= qPtrWidth'(freeHead);
                        qState[i].count <= qState[i].count + 1'b1;
                    end
                    2'b01: begin
                        qState[i].head  <= qPtrWidth'(nextPtr[addressWidth'(qState[i].head)]);
                        qState[i].count <= qState[i].count - 1'b1;
                    end
                    2'b11: begin
                        // A single-cell queue hands head over to the arriving cell.
                        if (qState[i].count == qCountWidth'(1)) qState[i].head <= qPtrWidth'(freeHead);
                        else qState[i].head <= qPtrWidth'(nextPtr[addressWidth'(qState[i].head)]);
                        qState[i].tail <= qPtrWidth'(freeHead);
                    end
                    default: ;
                endcase
            end
        end
    end

    // An empty queue's tail is stale and may now belong to another queue; never link through it.
    always_ff @(posedge clk) begin
        if (linkTail) nextPtr[enqTail] <= freeHead;
    end

    always_comb begin
        for (int i = 0; i < nbrOfQueues; i++) begin
            queueCount[i] = countWidth'(qState[i].count);
            queueEmpty[i] = (qState[i].count == '0);
        end
    end

    freeAddrFifo #(
        .depth(addresses),
        .width(addressWidth)
    ) uFreeList (
        .clk     (clk),
        .rst     (rst),
        .push    (freePush),
        .pushData(freePushData),
        .pop     (enqAccept),
        .popData (freeHead),
        .count   (freeCount)
    );

    twoPortMem #(
        .dataWidth(cellWidth),
        .depth    (addresses)
    ) uCellMem (
        .clk   (clk),
        .rst   (rst),
        .wrEn  (enqAccept),
        .wrAddr(freeHead),
        .wrData(enqData),
        .rdEn  (deqOk),
        .rdAddr(deqHead),
        .rdData(deqData)
    );
endmodule

// File: tb/tb_cell_queue_buffer.sv
// Scoreboard bench for cell_queue_buffer: queue-based reference model, decoupled deqData monitor.
module tb_cell_queue_buffer;
    localparam int NQ = 4, CW = 512, NA = 64, MAXC = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic enqValid = 1'b0, deqReq = 1'b0;
    logic [1:0] enqQueue = '0, deqQueue = '0;
    logic [CW-1:0] enqData = '0;
    logic enqAccept, enqReject, deqError, deqDataValid, initDone;
    logic [5:0] enqAddress;
    logic [CW-1:0] deqData;
    logic [NQ-1:0] queueEmpty;
    logic [NQ-1:0][5:0] queueCount;
    logic [6:0] freeCount;

    int checks = 0, errors = 0;
    logic [CW-1:0] mq[NQ][$];
    int ma[NQ][$];
    int mf[$];
    logic [CW-1:0] expData[$];

    always #5 clk = ~clk;

    cell_queue_buffer dut (
        .clk(clk), .rst(rst),
        .enqValid(enqValid), .enqQueue(enqQueue), .enqData(enqData),
        .enqAccept(enqAccept), .enqReject(enqReject), .enqAddress(enqAddress),
        .deqReq(deqReq), .deqQueue(deqQueue), .deqError(deqError),
        .deqDataValid(deqDataValid), .deqData(deqData),
        .queueEmpty(queueEmpty), .queueCount(queueCount),
        .freeCount(freeCount), .initDone(initDone)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] rndData();
        logic [CW-1:0] d;
        for (int i = 0; i < CW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic clearModel();
        for (int q = 0; q < NQ; q++) begin
            mq[q].delete();
            ma[q].delete();
        end
        mf.delete();
        expData.delete();
    endtask

    task automatic checkCounts();
        for (int q = 0; q < NQ; q++) begin
            check($sformatf("queueCount[%0d]", q), queueCount[q], mq[q].size());
            check($sformatf("queueEmpty[%0d]", q), queueEmpty[q], mq[q].size() == 0);
        end
        check("freeCount", freeCount, mf.size());
    endtask

    task automatic doCycle(input bit ev, input int eq, input logic [CW-1:0] ed, input bit dr, input int dq);
        bit expAcc, deqHappened, freeLater;
        int freed;
        freeLater = 1'b0;
        @(negedge clk);
        enqValid = ev; enqQueue = 2'(eq); enqData = ed;
        deqReq = dr; deqQueue = 2'(dq);
        #1;
        expAcc      = ev && (mf.size() > 0) && (mq[eq].size() < MAXC);
        deqHappened = dr && (mq[dq].size() > 0);
        check("enqAccept", enqAccept, expAcc);
        check("enqReject", enqReject, ev && !expAcc);
        check("deqError", deqError, dr && !deqHappened);
        if (expAcc) check("enqAddress", enqAddress, mf[0]);
        if (deqHappened) begin
            expData.push_back(mq[dq].pop_front());
            freed = ma[dq].pop_front();
            freeLater = 1'b1;
        end
        if (expAcc) begin
            ma[eq].push_back(mf.pop_front());
            mq[eq].push_back(ed);
        end
        if (freeLater) mf.push_back(freed);
        @(posedge clk);
        #1;
        check("deqDataValid", deqDataValid, deqHappened);
        checkCounts();
        enqValid = 1'b0; deqReq = 1'b0;
    endtask

    task automatic doReset(input bit withDeq);
        @(negedge clk);
        rst = 1'b1; enqValid = 1'b0; deqReq = withDeq; deqQueue = 2'd1;
        #1;
        check("rst enqAccept", enqAccept, 0);
        check("rst enqReject", enqReject, 0);
        check("rst enqAddress", enqAddress, 0);
        check("rst deqError", deqError, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst deqDataValid", deqDataValid, 0);
        check("rst deqData", (deqData == '0), 1);
        check("rst queueEmpty", queueEmpty, 4'hF);
        check("rst queueCount", queueCount, 0);
        check("rst freeCount", freeCount, 0);
        check("rst initDone", initDone, 0);
        deqReq = 1'b0;
        clearModel();
    endtask

    task automatic runInit();
        int n;
        bit ev, dr;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            rst = 1'b0;
            ev = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            enqValid = ev; enqQueue = 2'($urandom_range(0, 3)); enqData = rndData();
            deqReq = dr; deqQueue = 2'($urandom_range(0, 3));
            #1;
            check("init enqReject", enqReject, ev);
            check("init enqAccept", enqAccept, 0);
            check("init deqError", deqError, 0);
            @(posedge clk);
            #1;
            n++;
            if (initDone) break;
        end
        enqValid = 1'b0; deqReq = 1'b0;
        check("initDone latency", n, NA);
        check("init freeCount", freeCount, NA);
        check("init queueEmpty", queueEmpty, 4'hF);
        check("init queueCount", queueCount, 0);
        for (int a = 0; a < NA; a++) mf.push_back(a);
    endtask

    initial begin : monitor
        logic [CW-1:0] lastData, e;
        lastData = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                lastData = '0;
            end else if (deqDataValid) begin
                checks++;
                if (expData.size() == 0) begin
                    errors++;
                    $display("FAIL deqData unexpected valid: got %h expected none", deqData);
                end else begin
                    e = expData.pop_front();
                    if (deqData !== e) begin
                        errors++;
                        $display("FAIL deqData: got %h expected %h", deqData, e);
                    end
                end
                lastData = deqData;
            end else begin
                checks++;
                if (deqData !== lastData) begin
                    errors++;
                    $display("FAIL deqData hold: got %h expected %h", deqData, lastData);
                end
            end
        end
    end

    initial begin
        doReset(1'b0);
        runInit();

        // Three cells through queue 2, then out in order.
        for (int i = 0; i < 3; i++) doCycle(1, 2, rndData(), 0, 0);
        for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 1, 2);

        // Empty-queue dequeue, then same-cycle enq/deq on a one-cell queue.
        doCycle(0, 0, '0, 1, 3);
        doCycle(1, 3, rndData(), 0, 0);
        doCycle(1, 3, rndData(), 1, 3);
        doCycle(0, 0, '0, 1, 3);

        // Per-queue limit, then fill the whole pool and contend on the last slot.
        for (int i = 0; i < MAXC + 1; i++) doCycle(1, 0, rndData(), 0, 0);
        for (int i = 0; i < MAXC; i++) doCycle(1, 1, rndData(), 0, 0);
        doCycle(1, 0, rndData(), 1, 0);
        doCycle(1, 2, rndData(), 1, 0);
        doCycle(1, 2, rndData(), 0, 0);
        for (int i = 0; i < 80; i++) doCycle(0, 0, '0, 1, i % NQ);

        for (int i = 0; i < 1500; i++)
            doCycle(1'($urandom_range(0, 1)), $urandom_range(0, NQ - 1), rndData(),
                    1'($urandom_range(0, 1)), $urandom_range(0, NQ - 1));

        // Reset while queue 1 holds five cells and a dequeue is being requested.
        doReset(1'b0);
        runInit();
        for (int i = 0; i < 5; i++) doCycle(1, 1, rndData(), 0, 0);
        doReset(1'b1);
        runInit();
        for (int i = 0; i < 3; i++) doCycle(0, 0, '0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
